alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: operand, ALU and result width.
REQ-002 Parameter CNT_W, default 5: width of the iteration-count field.
REQ-003 The clock port SHALL be: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The reset port SHALL be: rst_n, input, 1, asynchronous active-low reset.
REQ-005 The command-side ports SHALL be:
- cmd_valid, input, 1: a command is offered.
- cmd_ready, output, 1: the block can accept a command.
- cmd_op, input, 2: ALU operation. 00 add, 01 AND, 10 shift right by 1, 11 increment.
- cmd_a, input, WIDTH: initial operand A.
- cmd_b, input, WIDTH: operand B.
- cmd_count, input, CNT_W: number of ALU passes; 0 means 1.
REQ-006 The ALU-side ports SHALL be:
- alu_a, output, WIDTH: drives the ALU input_a.
- alu_b, output, WIDTH: drives the ALU input_b.
- alu_op, output, 2: drives the ALU op_select.
- alu_out, input, WIDTH: the ALU's combinational result.
REQ-007 The result-side ports SHALL be:
- res_valid, output, 1: a result is available.
- res_ready, input, 1: the consumer accepts the result.
- res_data, output, WIDTH: the final result.

Function
REQ-008 The block SHALL implement an FSM with states IDLE, RUN and DONE, encoded internally.
REQ-009 cmd_ready SHALL be 1 exactly when the state is IDLE; res_valid SHALL be 1 exactly when the state is DONE.
REQ-010 Command acceptance (cmd_valid && cmd_ready at a rising edge) SHALL:
- load alu_a with cmd_a, alu_b with cmd_b and alu_op with cmd_op;
- load the remaining-pass counter with cmd_count, or with 1 if cmd_count is 0;
- move the state to RUN.
REQ-011 On each RUN-state edge the block SHALL load alu_a with alu_out and decrement the remaining-pass counter; alu_b and alu_op SHALL hold.
REQ-012 On the RUN edge where the remaining-pass counter equals 1, the block SHALL also load res_data with alu_out and move to DONE.
REQ-013 Latency SHALL be exactly N clock cycles from the acceptance edge to the edge that asserts res_valid, where N is the effective pass count (1..2^CNT_W-1).
REQ-014 The resulting values SHALL be as follows (all arithmetic modulo 2^WIDTH, carries discarded):
- add gives A + N*B;
- AND gives A & B;
- shift gives A >> N, logical, with zero fill;
- increment gives A + N.
REQ-015 In DONE, res_data SHALL hold stable until res_valid && res_ready at a rising edge, which SHALL move the state to IDLE.
REQ-016 cmd_valid SHALL be ignored in RUN and DONE, and no command SHALL be accepted on the same edge as a result handshake; the earliest next acceptance is the edge after the result handshake.
REQ-017 The command fields SHALL be sampled only at the acceptance edge; later changes on them SHALL have no effect on the current operation.
REQ-018 In IDLE and DONE, alu_a, alu_b and alu_op SHALL hold their last values.
REQ-019 res_ready SHALL be ignored outside DONE.
REQ-020 All outputs other than cmd_ready and res_valid SHALL be driven directly from registers.

Reset
REQ-021 While rst_n is 0, and immediately on its falling edge regardless of clk, the block SHALL be in the following reset state:
- state IDLE;
- alu_a, alu_b, res_data and the pass counter all 0;
- alu_op 00;
- cmd_ready 1 and res_valid 0.
REQ-022 A reset asserted during RUN or DONE SHALL abort the operation with no result delivered.
REQ-023 After rst_n deasserts, the first rising edge with cmd_valid high SHALL accept a command.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios:
- Add: cmd_op=00, a=5, b=3, count=1 -> res_valid rises 1 cycle after acceptance; res_data=8.
- Shift: cmd_op=10, a=0x80000000, count=4 -> res_valid after 4 cycles; res_data=0x08000000. alu_a takes 0x40000000, 0x20000000, 0x10000000 on successive edges.
- Increment wrap: cmd_op=11, a=0xFFFFFFFF, count=2 -> res_data=0x00000001.
- Count zero: cmd_op=01, a=0xF0F0F0F0, b=0xFF00FF00, count=0 -> treated as 1 pass; res_data=0xF000F000.
- Backpressure: res_ready held 0 for 5 cycles in DONE while cmd_valid=1 with new fields. Required response:
  - res_valid stays 1, res_data stays unchanged and cmd_ready stays 0;
  - after the res_ready=1 handshake the state is IDLE, and the new command is accepted on the following edge.
- Mid-run reset: add, count=20, rst_n pulsed low at pass 7 -> outputs take reset values immediately with no clk edge; no res_valid follows. A fresh command after release completes with correct latency.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-pass ALU sequencer: latches a command, feeds the external ALU's result back
// into operand A for N passes, then holds the final value until the consumer takes it.
module alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= 2'b00;
            res_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a  <= cmd_a;
                        alu_b  <= cmd_b;
                        alu_op <= cmd_op;
                        // A zero count still performs a single pass
                        cnt    <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    alu_a <= alu_out;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        res_data <= alu_out;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // Return to IDLE only; acceptance waits for the following edge
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
